mem_port_arbiter: RTL and testbench

//  Shares one single-port word memory between the fetch stage (IF) and the data stage (DM: lw/sw as decoded by the controller).

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the memory port arbiter slice.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_DM
  } grant_t;

  localparam int WAIT_W = 3;

  // A word access must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] byte_offset);
    return byte_offset != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter that sequences RAM wait states; done while count is zero.
module mem_wait_timer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [WAIT_W-1:0] value,
  output logic              done
);

  logic [WAIT_W-1:0] count;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between the fetch (IF) and data (DM) stages.
// DM wins ties because it belongs to the older instruction; a port just served
// is ignored in ACK so the other port gets the next slot.
// Optional build macro MEM_ARB_ALIGN_CHECK_EN rejects misaligned accesses with
// an err ack instead of touching the RAM.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_t state_q, state_d;
  grant_t     grant_q, grant_d;

  logic              take_if, take_dm, take;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic              grant_bad;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              first_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              timer_done;

  mem_wait_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (take),
    .en    (state_q == BUSY),
    .value (WAIT_W'(WAIT_STATES)),
    .done  (timer_done)
  );

  // Next-state and grant selection; a grant can be issued from IDLE or from ACK.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    take_if = 1'b0;
    take_dm = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req) begin
          take_dm = 1'b1;
        end else if (if_req) begin
          take_if = 1'b1;
        end
      end
      BUSY: begin
        if (timer_done) begin
          state_d = ACK;
        end
      end
      ACK: begin
        if ((grant_q == GNT_IF) && dm_req) begin
          take_dm = 1'b1;
        end else if ((grant_q == GNT_DM) && if_req) begin
          take_if = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = GNT_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
    if (take_dm) begin
      grant_d = GNT_DM;
    end else if (take_if) begin
      grant_d = GNT_IF;
    end
    if (take_dm || take_if) begin
      state_d = grant_bad ? ACK : BUSY;
    end
  end

  // Mux the winning requester's access fields for capture at grant time.
  always_comb begin
    take      = take_if || take_dm;
    sel_addr  = take_dm ? dm_addr : if_addr;
    sel_we    = take_dm && dm_we;
    sel_wdata = take_dm ? dm_wdata : '0;
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic err_q;

  assign grant_bad = is_misaligned(sel_addr[1:0]);

  // Remember whether the current grant was rejected so the ack carries err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (take) begin
      err_q <= grant_bad;
    end
  end

  assign if_err = (state_q == ACK) && (grant_q == GNT_IF) && err_q;
  assign dm_err = (state_q == ACK) && (grant_q == GNT_DM) && err_q;
`else
  assign grant_bad = 1'b0;
  assign if_err    = 1'b0;
  assign dm_err    = 1'b0;
`endif

  // FSM state and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Capture the granted access, track the strobe cycle and latch read data at the end of BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      first_q    <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (take) begin
      addr_q  <= sel_addr;
      we_q    <= sel_we;
      wdata_q <= sel_wdata;
      first_q <= !grant_bad;
      if (grant_bad) begin
        if (take_dm) begin
          dm_rdata_q <= '0;
        end else begin
          if_rdata_q <= '0;
        end
      end
    end else if (state_q == BUSY) begin
      first_q <= 1'b0;
      if (timer_done) begin
        if (grant_q == GNT_DM) begin
          if (!we_q) begin
            dm_rdata_q <= ram_rdata;
          end
        end else begin
          if_rdata_q <= ram_rdata;
        end
      end
    end
  end

  assign ram_en    = (state_q == BUSY) && first_q;
  assign ram_we    = (state_q == BUSY) && we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign if_ack    = (state_q == ACK) && (grant_q == GNT_IF);
  assign dm_ack    = (state_q == ACK) && (grant_q == GNT_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter at WAIT_STATES 1, 0 and 7.
// Honours MEM_ARB_ALIGN_CHECK_EN for the misaligned-access step.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] ram_rdata = '0;
  logic        dm_req0 = 1'b0;
  logic        dm_req7 = 1'b0;
  logic        idle_req = 1'b0;

  logic        if_ack, if_err, dm_ack, dm_err, ram_en, ram_we;
  logic [31:0] if_rdata, dm_rdata, ram_addr, ram_wdata;

  logic        o0_if_ack, o0_if_err, o0_dm_ack, o0_dm_err, o0_ram_en, o0_ram_we;
  logic [31:0] o0_if_rdata, o0_dm_rdata, o0_ram_addr, o0_ram_wdata;

  logic        o7_if_ack, o7_if_err, o7_dm_ack, o7_dm_err, o7_ram_en, o7_ram_we;
  logic [31:0] o7_if_rdata, o7_dm_rdata, o7_ram_addr, o7_ram_wdata;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int ack_cycle;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(idle_req), .if_addr(if_addr), .if_ack(o0_if_ack), .if_rdata(o0_if_rdata), .if_err(o0_if_err),
    .dm_req(dm_req0), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(o0_dm_ack), .dm_rdata(o0_dm_rdata), .dm_err(o0_dm_err),
    .ram_en(o0_ram_en), .ram_we(o0_ram_we), .ram_addr(o0_ram_addr), .ram_wdata(o0_ram_wdata),
    .ram_rdata(ram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(7)) dut7 (
    .clk(clk), .rst(rst),
    .if_req(idle_req), .if_addr(if_addr), .if_ack(o7_if_ack), .if_rdata(o7_if_rdata), .if_err(o7_if_err),
    .dm_req(dm_req7), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(o7_dm_ack), .dm_rdata(o7_dm_rdata), .dm_err(o7_dm_err),
    .ram_en(o7_ram_en), .ram_we(o7_ram_we), .ram_addr(o7_ram_addr), .ram_wdata(o7_ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance to the middle of the next cycle (falling edge).
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #2 rst = 1'b1;
    step();
    $display("[TB] reset state");
    check_output("rst_ram_en", 32'(ram_en), 0);
    check_output("rst_ram_we", 32'(ram_we), 0);
    check_output("rst_ram_addr", ram_addr, 0);
    check_output("rst_ram_wdata", ram_wdata, 0);
    check_output("rst_if_ack", 32'(if_ack), 0);
    check_output("rst_dm_ack", 32'(dm_ack), 0);
    check_output("rst_if_rdata", if_rdata, 0);
    check_output("rst_dm_rdata", dm_rdata, 0);
    check_output("rst_if_err", 32'(if_err), 0);
    check_output("rst_dm_err", 32'(dm_err), 0);
    rst = 1'b0;

    $display("[TB] single fetch");
    if_req = 1'b1; if_addr = 32'h40; ram_rdata = 32'h2002000A;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_output($sformatf("if_ram_en_c%0d", c), 32'(ram_en), 32'(c == 1));
      check_output($sformatf("if_ack_c%0d", c), 32'(if_ack), 32'(c == 3));
      if (c == 1) begin
        check_output("if_ram_addr", ram_addr, 32'h40);
        check_output("if_ram_we", 32'(ram_we), 0);
      end
      if (c == 3) begin
        check_output("if_rdata", if_rdata, 32'h2002000A);
        check_output("if_err", 32'(if_err), 0);
        if_req = 1'b0;
      end
    end

    $display("[TB] load, 1 wait state");
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104; ram_rdata = 32'h12345678;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_output($sformatf("lw_ram_en_c%0d", c), 32'(ram_en), 32'(c == 1));
      check_output($sformatf("lw_dm_ack_c%0d", c), 32'(dm_ack), 32'(c == 3));
      if (c == 1) begin
        check_output("lw_ram_addr", ram_addr, 32'h104);
        check_output("lw_ram_we", 32'(ram_we), 0);
      end
      if (c == 3) begin
        check_output("lw_dm_rdata", dm_rdata, 32'h12345678);
        dm_req = 1'b0;
      end
    end

    $display("[TB] load, 0 wait states");
    dm_req0 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check_output($sformatf("ws0_ram_en_c%0d", c), 32'(o0_ram_en), 32'(c == 1));
      check_output($sformatf("ws0_dm_ack_c%0d", c), 32'(o0_dm_ack), 32'(c == 2));
      if (c == 2) begin
        check_output("ws0_dm_rdata", o0_dm_rdata, 32'h12345678);
        dm_req0 = 1'b0;
      end
    end

    $display("[TB] load, 7 wait states");
    dm_req7 = 1'b1;
    ack_cycle = 0;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (o7_dm_ack && (ack_cycle == 0)) begin
        ack_cycle = c;
        dm_req7 = 1'b0;
      end
    end
    check_output("ws7_ack_cycle", 32'(ack_cycle), 9);
    check_output("ws7_dm_rdata", o7_dm_rdata, 32'h12345678);

    $display("[TB] reset during load");
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104; ram_rdata = 32'hCAFEF00D;
    step();
    check_output("abort_ram_en_c1", 32'(ram_en), 1);
    step();
    rst = 1'b1;
    #1;
    check_output("abort_ram_en", 32'(ram_en), 0);
    check_output("abort_ram_addr", ram_addr, 0);
    check_output("abort_dm_ack", 32'(dm_ack), 0);
    check_output("abort_dm_rdata", dm_rdata, 0);
    step();
    check_output("abort_dm_ack_held", 32'(dm_ack), 0);
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_output($sformatf("restart_ram_en_c%0d", c), 32'(ram_en), 32'(c == 1));
      check_output($sformatf("restart_dm_ack_c%0d", c), 32'(dm_ack), 32'(c == 3));
      if (c == 3) begin
        check_output("restart_dm_rdata", dm_rdata, 32'hCAFEF00D);
        dm_req = 1'b0;
      end
    end

    $display("[TB] simultaneous store and fetch");
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
    ram_rdata = 32'h0BADF00D;
    for (int c = 1; c <= 7; c++) begin
      step();
      check_output($sformatf("both_ram_en_c%0d", c), 32'(ram_en), 32'((c == 1) || (c == 4)));
      check_output($sformatf("both_dm_ack_c%0d", c), 32'(dm_ack), 32'(c == 3));
      check_output($sformatf("both_if_ack_c%0d", c), 32'(if_ack), 32'(c == 6));
      if (c == 1) begin
        check_output("sw_ram_we", 32'(ram_we), 1);
        check_output("sw_ram_addr", ram_addr, 32'h100);
        check_output("sw_ram_wdata", ram_wdata, 32'hDEADBEEF);
      end
      if (c == 3) begin
        check_output("sw_dm_rdata_kept", dm_rdata, 32'hCAFEF00D);
        check_output("sw_dm_err", 32'(dm_err), 0);
        dm_req = 1'b0; dm_we = 1'b0;
      end
      if (c == 4) begin
        check_output("if2_ram_addr", ram_addr, 32'h80);
        check_output("if2_ram_we", 32'(ram_we), 0);
      end
      if (c == 6) begin
        check_output("if2_rdata", if_rdata, 32'h0BADF00D);
        if_req = 1'b0;
      end
    end

    $display("[TB] back-to-back fetches");
    if_req = 1'b1; if_addr = 32'h200; ram_rdata = 32'hA0000200;
    for (int c = 1; c <= 12; c++) begin
      step();
      check_output($sformatf("b2b_if_ack_c%0d", c), 32'(if_ack), 32'((c % 4) == 3));
      check_output($sformatf("b2b_dual_ack_c%0d", c), 32'(if_ack && dm_ack), 0);
      if ((c % 4) == 1) begin
        check_output($sformatf("b2b_ram_addr_c%0d", c), ram_addr, if_addr);
      end
      if (if_ack) begin
        check_output($sformatf("b2b_rdata_c%0d", c), if_rdata, ram_rdata);
        if_addr = if_addr + 32'd4;
        ram_rdata = 32'hA0000000 | if_addr;
      end
    end
    if_req = 1'b0;
    step();
    step();

    $display("[TB] misaligned load");
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h102; ram_rdata = 32'h55AA55AA;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    step();
    check_output("mis_ram_en", 32'(ram_en), 0);
    check_output("mis_dm_ack", 32'(dm_ack), 1);
    check_output("mis_dm_err", 32'(dm_err), 1);
    check_output("mis_dm_rdata", dm_rdata, 0);
    dm_req = 1'b0;
    step();
    check_output("mis_dm_ack_after", 32'(dm_ack), 0);
    check_output("mis_ram_en_after", 32'(ram_en), 0);
`else
    for (int c = 1; c <= 4; c++) begin
      step();
      check_output($sformatf("mis_ram_en_c%0d", c), 32'(ram_en), 32'(c == 1));
      check_output($sformatf("mis_dm_ack_c%0d", c), 32'(dm_ack), 32'(c == 3));
      if (c == 1) begin
        check_output("mis_ram_addr", ram_addr, 32'h102);
      end
      if (c == 3) begin
        check_output("mis_dm_err", 32'(dm_err), 0);
        check_output("mis_dm_rdata", dm_rdata, 32'h55AA55AA);
        dm_req = 1'b0;
      end
    end
`endif

    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
